ps2_drive_cmd_ctrl: RTL and testbench
=====================================

PS2_DRIVE_CMD_CTRL -- requirements
Module: ps2_drive_cmd_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1000000, number of clocks without a new byte before a partial prefix sequence is abandoned.
REQ-002 Port: CLOCK_50  in  1  system clock; all state changes on its rising edge.
REQ-003 Port: resetn  in  1  reset, asynchronous and active-low.
REQ-004 Port: rx_data  in  8  PS/2 scan-code byte from the PS/2 receiver.
REQ-005 Port: rx_valid  in  1  single-cycle strobe; rx_data is valid in the same cycle.
REQ-006 Port: accel  out  2  drive command: 2'b10 forward, 2'b01 backward, 2'b00 none.
REQ-007 Port: steer  out  2  steer command: 2'b10 left, 2'b01 right, 2'b00 none.
REQ-008 Port: keys_held  out  4  held flags {fwd, back, left, right}.
REQ-009 Port: err_pulse  out  1  one-cycle pulse on prefix timeout.

Function
REQ-010 Key map: fwd = 0x73 or E0 0x75; back = 0x72 or E0 0x72; left = 0x6B or E0 0x6B; right = 0x74 or E0 0x74.
REQ-011 Both aliases of a key SHALL drive one shared held flag; any alias make sets the flag, and any alias break clears it.
REQ-012 The decoder FSM SHALL have four states: IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen).
REQ-013 FSM transitions SHALL occur only on cycles where rx_valid=1.
REQ-014 IDLE: byte 0xF0 -> BRK; byte 0xE0 -> EXT; any other byte is a non-extended make, and the FSM stays in IDLE.
REQ-015 BRK: a matching non-extended code SHALL clear its flag; any byte SHALL return the FSM to IDLE.
REQ-016 EXT: byte 0xF0 -> EXT_BRK; any other byte is an extended make -> IDLE.
REQ-017 EXT_BRK: a matching extended code SHALL clear its flag; any byte SHALL return the FSM to IDLE.
REQ-018 Unmapped codes SHALL complete the sequence but leave all flags unchanged.
REQ-019 A make of an already-held key (typematic repeat) SHALL leave the held flags and the priority bits unchanged.
REQ-020 Priority bit pri_fb SHALL record which of fwd/back most recently went 0->1; pri_lr SHALL do the same for left/right.
REQ-021 accel SHALL be: fwd only -> 10; back only -> 01; both held -> direction of pri_fb; neither -> 00.
REQ-022 steer SHALL use the same rule with left/right and pri_lr.
REQ-023 When both keys of a pair are held and the newer one is released, the output SHALL fall back to the older key with no 00 gap.
REQ-024 accel, steer and keys_held SHALL be combinational from registered state; they reflect a completed sequence in the cycle after its final byte's rx_valid.
REQ-025 The timeout counter SHALL clear on every rx_valid and while in IDLE, and SHALL increment otherwise.
REQ-026 When the counter reaches TIMEOUT_CYCLES-1 outside IDLE, the FSM SHALL go to IDLE, err_pulse SHALL be 1 for exactly one cycle, and flags SHALL be unchanged.
REQ-027 If rx_valid coincides with the timeout cycle, the byte SHALL take precedence and no err_pulse SHALL be generated.
REQ-028 The counter SHALL be wide enough for TIMEOUT_CYCLES without wrap-around and SHALL saturate.

Reset
REQ-029 resetn=0 SHALL asynchronously force: FSM=IDLE, keys_held=0, pri_fb=0, pri_lr=0, counter=0, accel=00, steer=00, err_pulse=0.
REQ-030 Reset in the middle of a sequence SHALL discard the partial prefix; the first byte after release is decoded from IDLE.
REQ-031 rx_valid asserted while resetn=0 SHALL be ignored.

Verification
REQ-032 Bytes 73, then F0 73 -> accel=10 after the first byte; accel=00 the cycle after the second 73; keys_held=0000 at the end.
REQ-033 Bytes 73, then E0 72 -> accel=01 (newest wins); then E0 F0 72 -> accel=10 with no intervening 00.
REQ-034 Make 0x73, then E0 F0 75 -> fwd flag clears (alias break); 73 73 73 repeated -> pri_fb is unchanged and accel stays 10.
REQ-035 Byte E0, then idle for TIMEOUT_CYCLES (set to 16 on the bench) -> one err_pulse; the next byte 0x6B is a plain make -> steer=10.
REQ-036 Bytes F0 15 -> no flag change; 6B then 74 -> steer=01; resetn pulse mid-sequence after an E0 -> all outputs 0, and a subsequent 72 gives accel=01.

Source files
------------

// File: rtl/ps2_drive_cmd_ctrl.sv
// PS/2 scan-code decoder: turns make/break sequences for the drive keys into held flags
// and accel/steer commands, with newest-key-wins arbitration and a prefix timeout.
module ps2_drive_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [1:0] accel,
  output logic [1:0] steer,
  output logic [3:0] keys_held,
  output logic       err_pulse
);

  // state   | meaning
  // IDLE    | no prefix pending
  // BRK     | F0 seen, next byte is a non-extended break
  // EXT     | E0 seen, next byte is an extended make unless F0
  // EXT_BRK | E0 F0 seen, next byte is an extended break
  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       held_q, held_d;
  logic             pri_fb_q, pri_fb_d;
  logic             pri_lr_q, pri_lr_d;
  logic             err_q, err_d;

  logic [3:0] make_vec, brk_vec, std_key, ext_key, new_set;
  logic       timeout_hit;

  // Flag vector order is {fwd, back, left, right}
  always_comb begin
    std_key = 4'b0000;
    case (rx_data)
      8'h73: std_key = 4'b1000;
      8'h72: std_key = 4'b0100;
      8'h6B: std_key = 4'b0010;
      8'h74: std_key = 4'b0001;
      default: std_key = 4'b0000;
    endcase
  end

  always_comb begin
    ext_key = 4'b0000;
    case (rx_data)
      8'h75: ext_key = 4'b1000;
      8'h72: ext_key = 4'b0100;
      8'h6B: ext_key = 4'b0010;
      8'h74: ext_key = 4'b0001;
      default: ext_key = 4'b0000;
    endcase
  end

  assign timeout_hit = (state_q != IDLE) && !rx_valid && (cnt_q == CNT_LAST);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rx_valid) begin
      case (state_q)
        IDLE: begin
          if (rx_data == 8'hF0)      state_d = BRK;
          else if (rx_data == 8'hE0) state_d = EXT;
          else                       state_d = IDLE;
        end
        EXT:     state_d = (rx_data == 8'hF0) ? EXT_BRK : IDLE;
        default: state_d = IDLE;
      endcase
    end else if (timeout_hit) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    make_vec = 4'b0000;
    brk_vec  = 4'b0000;
    err_d    = timeout_hit;
    if (rx_valid) begin
      case (state_q)
        IDLE:    if (rx_data != 8'hF0 && rx_data != 8'hE0) make_vec = std_key;
        BRK:     brk_vec = std_key;
        EXT:     if (rx_data != 8'hF0) make_vec = ext_key;
        EXT_BRK: brk_vec = ext_key;
        default: ;
      endcase
    end
  end

  // Repeats of an already-held key produce no new_set bit, so priority stays put
  assign new_set = make_vec & ~held_q;
  assign held_d  = (held_q | make_vec) & ~brk_vec;

  always_comb begin
    pri_fb_d = pri_fb_q;
    pri_lr_d = pri_lr_q;
    if (new_set[3])      pri_fb_d = 1'b1;
    else if (new_set[2]) pri_fb_d = 1'b0;
    if (new_set[1])      pri_lr_d = 1'b1;
    else if (new_set[0]) pri_lr_d = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (rx_valid || state_q == IDLE) cnt_d = '0;
    else if (cnt_q != '1)            cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      cnt_q    <= '0;
      held_q   <= 4'b0000;
      pri_fb_q <= 1'b0;
      pri_lr_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      held_q   <= held_d;
      pri_fb_q <= pri_fb_d;
      pri_lr_q <= pri_lr_d;
      err_q    <= err_d;
    end
  end

  assign keys_held = held_q;
  assign err_pulse = err_q;
  assign accel = (held_q[3] && held_q[2]) ? (pri_fb_q ? 2'b10 : 2'b01) : held_q[3:2];
  assign steer = (held_q[1] && held_q[0]) ? (pri_lr_q ? 2'b10 : 2'b01) : held_q[1:0];

endmodule

// File: tb/tb_ps2_drive_cmd_ctrl.sv
// Directed bench for ps2_drive_cmd_ctrl: byte sequences with hand-computed
// accel/steer/keys_held/err_pulse expectations, timeout set to 16 cycles.
module tb_ps2_drive_cmd_ctrl;
  logic       clk;
  logic       resetn;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [1:0] accel;
  logic [1:0] steer;
  logic [3:0] keys_held;
  logic       err_pulse;

  int tests_run    = 0;
  int tests_failed = 0;
  int err_count;
  int first_err;

  ps2_drive_cmd_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .accel    (accel),
    .steer    (steer),
    .keys_held(keys_held),
    .err_pulse(err_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one byte for one cycle; returns at the falling edge after it was captured
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [1:0] a, input logic [1:0] s,
                         input logic [3:0] k);
    chk({tag, "_accel"}, 32'(accel), 32'(a));
    chk({tag, "_steer"}, 32'(steer), 32'(s));
    chk({tag, "_keys"}, 32'(keys_held), 32'(k));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn   = 1'b0;
    rx_data  = 8'h73;
    rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk_out("reset", 2'b00, 2'b00, 4'b0000);
    chk("reset_err", 32'(err_pulse), 32'd0);
    rx_valid = 1'b0;
    resetn   = 1'b1;
    @(negedge clk);
    chk_out("reset_rel", 2'b00, 2'b00, 4'b0000);

    // make then break of fwd
    send(8'h73); chk_out("fwd_make", 2'b10, 2'b00, 4'b1000);
    send(8'hF0); chk_out("fwd_f0", 2'b10, 2'b00, 4'b1000);
    send(8'h73); chk_out("fwd_brk", 2'b00, 2'b00, 4'b0000);

    // newest wins, fallback on release without 00 gap
    send(8'h73); chk_out("pr_fwd", 2'b10, 2'b00, 4'b1000);
    send(8'hE0); chk_out("pr_e0", 2'b10, 2'b00, 4'b1000);
    send(8'h72); chk_out("pr_back", 2'b01, 2'b00, 4'b1100);
    send(8'hE0); chk_out("pr_e0b", 2'b01, 2'b00, 4'b1100);
    send(8'hF0); chk_out("pr_f0b", 2'b01, 2'b00, 4'b1100);
    send(8'h72); chk_out("pr_fall", 2'b10, 2'b00, 4'b1000);

    // alias break of fwd
    send(8'hE0); send(8'hF0); send(8'h75);
    chk_out("alias_brk", 2'b00, 2'b00, 4'b0000);

    // typematic repeat must not move priority
    send(8'h73); send(8'h73); send(8'h73);
    chk_out("rep_fwd", 2'b10, 2'b00, 4'b1000);
    send(8'h72); chk_out("rep_back", 2'b01, 2'b00, 4'b1100);
    send(8'h73); send(8'h73); send(8'h73);
    chk_out("rep_keep", 2'b01, 2'b00, 4'b1100);
    send(8'hF0); send(8'h72); chk_out("rep_relb", 2'b10, 2'b00, 4'b1000);
    send(8'hF0); send(8'h73); chk_out("rep_relf", 2'b00, 2'b00, 4'b0000);

    // unmapped extended code
    send(8'hE0); send(8'h73); chk_out("unmap_ext", 2'b00, 2'b00, 4'b0000);

    // prefix timeout: err_pulse expected 16 cycles after E0 capture
    send(8'hE0);
    err_count = 0;
    first_err = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (err_pulse === 1'b1) begin
        err_count++;
        if (first_err < 0) first_err = k;
      end
    end
    chk("to_count", 32'(err_count), 32'd1);
    chk("to_when", 32'(first_err), 32'd16);
    chk_out("to_flags", 2'b00, 2'b00, 4'b0000);
    send(8'h6B); chk_out("to_next", 2'b00, 2'b10, 4'b0010);

    // byte arriving on the timeout cycle wins, no err_pulse
    send(8'hE0);
    repeat (15) @(negedge clk);
    rx_data  = 8'h74;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("coin_err0", 32'(err_pulse), 32'd0);
    err_count = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (err_pulse === 1'b1) err_count++;
    end
    chk("coin_errn", 32'(err_count), 32'd0);
    chk_out("coin_ext", 2'b00, 2'b01, 4'b0011);
    send(8'hE0); send(8'hF0); send(8'h74);
    chk_out("coin_rel", 2'b00, 2'b10, 4'b0010);
    send(8'hF0); send(8'h6B); chk_out("coin_clr", 2'b00, 2'b00, 4'b0000);

    // unmapped break, then plain left/right
    send(8'hF0); send(8'h15); chk_out("unmap_brk", 2'b00, 2'b00, 4'b0000);
    send(8'h6B); chk_out("lr_left", 2'b00, 2'b10, 4'b0010);
    send(8'h74); chk_out("lr_right", 2'b00, 2'b01, 4'b0011);

    // reset mid-sequence discards the E0 prefix
    send(8'hE0);
    #2 resetn = 1'b0;
    #1;
    chk_out("mid_rst", 2'b00, 2'b00, 4'b0000);
    chk("mid_rst_err", 32'(err_pulse), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    send(8'h75); chk_out("post_rst75", 2'b00, 2'b00, 4'b0000);
    send(8'h72); chk_out("post_rst72", 2'b01, 2'b00, 4'b0100);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
